// File: rtl/mc_controller_if.sv
// Memory-side handshake of the multicycle controller: request, store select,
// address source, and the variable-latency ready strobe from memory.
interface mc_controller_if;
  logic mem_req;
  logic mem_write;
  logic adr_src;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_write,
    output adr_src,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_write,
    input  adr_src,
    output mem_ready
  );
endinterface

// File: rtl/mc_controller.sv
// RV32I multicycle sequencer: 3-5 cycles per instruction with zero-wait memory.
// Backpressure: FETCH/MEMREAD/MEMWRITE hold with mem_req high until mem_ready.
module mc_controller (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [6:0]            i_op,
  input  logic [2:0]            i_funct3,
  input  logic                  i_funct7_5,
  input  logic                  i_zero,
  mc_controller_if.master       io_mem,
  output logic                  o_ir_write,
  output logic                  o_pc_write,
  output logic                  o_reg_write,
  output logic [1:0]            o_alu_src_a,
  output logic [1:0]            o_alu_src_b,
  output logic [1:0]            o_result_src,
  output logic [1:0]            o_imm_src,
  output logic [2:0]            o_alu_control,
  output logic                  o_instr_done,
  output logic                  o_illegal
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       fetch_wr;
    logic       pc_write;
    logic       reg_write;
    logic       done;
    logic       done_on_ready;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] result_src;
    logic [2:0] alu_ctrl;
  } ctrl_t;

  // Pure state-dependent controls; anything gated by mem_ready, funct3 or zero is
  // resolved combinationally below.
  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.mem_req    = 1'b1;
        c.fetch_wr   = 1'b1;
        c.src_b      = 2'b10;
        c.result_src = 2'b10;
      end
      DECODE: begin
        c.src_a = 2'b01;
        c.src_b = 2'b01;
      end
      MEMADR: begin
        c.src_a = 2'b10;
        c.src_b = 2'b01;
      end
      MEMREAD: begin
        c.mem_req = 1'b1;
        c.adr_src = 1'b1;
      end
      MEMWB: begin
        c.result_src = 2'b01;
        c.reg_write  = 1'b1;
        c.done       = 1'b1;
      end
      MEMWRITE: begin
        c.mem_req       = 1'b1;
        c.mem_write     = 1'b1;
        c.adr_src       = 1'b1;
        c.done_on_ready = 1'b1;
      end
      EXECR: begin
        c.src_a = 2'b10;
      end
      EXECI: begin
        c.src_a = 2'b10;
        c.src_b = 2'b01;
      end
      ALUWB: begin
        c.reg_write = 1'b1;
        c.done      = 1'b1;
      end
      BRANCH: begin
        c.src_a    = 2'b10;
        c.alu_ctrl = ALU_SUB;
      end
      JAL: begin
        c.src_a    = 2'b01;
        c.src_b    = 2'b10;
        c.pc_write = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t     r_state;
  ctrl_t      r_ctrl;
  logic       r_illegal;

  state_t     w_next;
  logic       w_ready;
  logic       w_f3_alu_ok;
  logic       w_f3_br_ok;
  logic       w_br_take;
  logic [2:0] w_alu_ctrl;
  logic [1:0] w_imm_src;

  assign w_ready     = io_mem.mem_ready;
  assign w_f3_alu_ok = (i_funct3 == 3'b000) || (i_funct3 == 3'b010) ||
                       (i_funct3 == 3'b110) || (i_funct3 == 3'b111);
  assign w_f3_br_ok  = (i_funct3 == 3'b000) || (i_funct3 == 3'b001);
  assign w_br_take   = ((i_funct3 == 3'b000) &&  i_zero) ||
                       ((i_funct3 == 3'b001) && !i_zero);

  always_comb begin
    w_next = r_state;
    case (r_state)
      FETCH:    w_next = w_ready ? DECODE : FETCH;
      DECODE: begin
        case (i_op)
          OP_LW, OP_SW: w_next = MEMADR;
          OP_R:         w_next = EXECR;
          OP_I:         w_next = EXECI;
          OP_BR:        w_next = BRANCH;
          OP_JAL:       w_next = JAL;
          default:      w_next = TRAP;
        endcase
      end
      MEMADR:   w_next = (i_op == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:  w_next = w_ready ? MEMWB : MEMREAD;
      MEMWB:    w_next = FETCH;
      MEMWRITE: w_next = w_ready ? FETCH : MEMWRITE;
      EXECR,
      EXECI:    w_next = w_f3_alu_ok ? ALUWB : TRAP;
      ALUWB:    w_next = FETCH;
      BRANCH:   w_next = w_f3_br_ok ? FETCH : TRAP;
      JAL:      w_next = ALUWB;
      default:  w_next = TRAP;
    endcase
  end

  // r_ctrl always holds state_ctrl(r_state), so the Moore outputs come straight off flops.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= FETCH;
      r_ctrl    <= state_ctrl(FETCH);
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_ctrl    <= state_ctrl(w_next);
      r_illegal <= r_illegal || (w_next == TRAP);
    end
  end

  always_comb begin
    w_alu_ctrl = r_ctrl.alu_ctrl;
    if ((r_state == EXECR) || (r_state == EXECI)) begin
      case (i_funct3)
        3'b000:  w_alu_ctrl = ((r_state == EXECR) && i_funct7_5) ? ALU_SUB : ALU_ADD;
        3'b010:  w_alu_ctrl = ALU_SLT;
        3'b110:  w_alu_ctrl = ALU_OR;
        3'b111:  w_alu_ctrl = ALU_AND;
        default: w_alu_ctrl = ALU_ADD;
      endcase
    end
  end

  always_comb begin
    w_imm_src = 2'b00;
    if (r_state == DECODE) begin
      if (i_op == OP_BR)       w_imm_src = 2'b10;
      else if (i_op == OP_JAL) w_imm_src = 2'b11;
    end else if (r_state == MEMADR && i_op == OP_SW) begin
      w_imm_src = 2'b01;
    end
  end

  assign io_mem.mem_req   = r_ctrl.mem_req   && !i_rst;
  assign io_mem.mem_write = r_ctrl.mem_write && !i_rst;
  assign io_mem.adr_src   = r_ctrl.adr_src;

  assign o_ir_write    = r_ctrl.fetch_wr && w_ready && !i_rst;
  assign o_pc_write    = !i_rst && ((r_ctrl.fetch_wr && w_ready) || r_ctrl.pc_write ||
                                    ((r_state == BRANCH) && w_br_take));
  assign o_reg_write   = r_ctrl.reg_write && !i_rst;
  assign o_instr_done  = !i_rst && (r_ctrl.done || (r_ctrl.done_on_ready && w_ready) ||
                                    ((r_state == BRANCH) && w_f3_br_ok));
  assign o_alu_src_a   = r_ctrl.src_a;
  assign o_alu_src_b   = r_ctrl.src_b;
  assign o_result_src  = r_ctrl.result_src;
  assign o_imm_src     = w_imm_src;
  assign o_alu_control = w_alu_ctrl;
  assign o_illegal     = r_illegal;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: per-instruction cycle counts and enable tallies.
module tb_mc_controller;
  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       zero;
  logic       ir_write, pc_write, reg_write, instr_done, illegal;
  logic [1:0] alu_src_a, alu_src_b, result_src, imm_src;
  logic [2:0] alu_control;
  int         n_checks = 0;
  int         n_errors = 0;

  mc_controller_if mem_bus ();

  mc_controller dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_op          (op),
    .i_funct3      (funct3),
    .i_funct7_5    (funct7_5),
    .i_zero        (zero),
    .io_mem        (mem_bus),
    .o_ir_write    (ir_write),
    .o_pc_write    (pc_write),
    .o_reg_write   (reg_write),
    .o_alu_src_a   (alu_src_a),
    .o_alu_src_b   (alu_src_b),
    .o_result_src  (result_src),
    .o_imm_src     (imm_src),
    .o_alu_control (alu_control),
    .o_instr_done  (instr_done),
    .o_illegal     (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input string tag, input logic [6:0] op_v, input logic [2:0] f3,
                           input logic f7, input logic z, input logic [15:0] rdy,
                           input int exp_cyc, input int exp_pcw, input int exp_rw,
                           input logic [1:0] exp_rs, input int exp_req, input int exp_mw,
                           input logic [1:0] exp_imm2, input logic [1:0] exp_imm3,
                           input logic [2:0] exp_alu3);
    int done_cyc = 0;
    int n_pcw = 0, n_rw = 0, n_req = 0, n_mw = 0, n_irw = 0;
    logic [1:0] rs_at_rw = 2'b00, imm2 = 2'b00, imm3 = 2'b00;
    logic [2:0] alu3 = 3'b000;
    op = op_v; funct3 = f3; funct7_5 = f7; zero = z;
    for (int i = 1; i <= 16 && done_cyc == 0; i++) begin
      mem_bus.mem_ready = rdy[i-1];
      #1;
      if (pc_write) n_pcw++;
      if (ir_write) n_irw++;
      if (mem_bus.mem_req) n_req++;
      if (mem_bus.mem_write) n_mw++;
      if (reg_write) begin n_rw++; rs_at_rw = result_src; end
      if (i == 2) imm2 = imm_src;
      if (i == 3) begin imm3 = imm_src; alu3 = alu_control; end
      if (instr_done) done_cyc = i;
      next_cycle();
    end
    check({tag, ".cycles"}, done_cyc, exp_cyc);
    check({tag, ".pcw"}, n_pcw, exp_pcw);
    check({tag, ".irw"}, n_irw, 1);
    check({tag, ".rw"}, n_rw, exp_rw);
    if (exp_rw > 0) check({tag, ".rsrc"}, rs_at_rw, exp_rs);
    check({tag, ".req"}, n_req, exp_req);
    check({tag, ".mw"}, n_mw, exp_mw);
    check({tag, ".imm2"}, imm2, exp_imm2);
    check({tag, ".imm3"}, imm3, exp_imm3);
    check({tag, ".alu3"}, alu3, exp_alu3);
  endtask

  task automatic trap_run(input string tag, input logic [6:0] op_v, input logic [2:0] f3,
                          input int exp_trap);
    int first_ill = 0, n_ill = 0;
    int n_pcw = 0, n_irw = 0, n_rw = 0, n_mw = 0, n_req = 0, n_done = 0;
    op = op_v; funct3 = f3; funct7_5 = 1'b0; zero = 1'b1;
    mem_bus.mem_ready = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      #1;
      if (illegal) begin n_ill++; if (first_ill == 0) first_ill = i; end
      if (pc_write) n_pcw++;
      if (ir_write) n_irw++;
      if (reg_write) n_rw++;
      if (mem_bus.mem_write) n_mw++;
      if (mem_bus.mem_req) n_req++;
      if (instr_done) n_done++;
      next_cycle();
    end
    check({tag, ".first_ill"}, first_ill, exp_trap);
    check({tag, ".ill_cycles"}, n_ill, 26 - exp_trap);
    check({tag, ".pcw"}, n_pcw, 1);
    check({tag, ".irw"}, n_irw, 1);
    check({tag, ".rw"}, n_rw, 0);
    check({tag, ".mw"}, n_mw, 0);
    check({tag, ".req"}, n_req, 1);
    check({tag, ".done"}, n_done, 0);
    rst = 1'b1;
    #1;
    check({tag, ".rst_req"}, mem_bus.mem_req, 0);
    next_cycle();
    rst = 1'b0;
    #1;
    check({tag, ".rst_ill"}, illegal, 0);
    check({tag, ".rst_fetch"}, mem_bus.mem_req, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; op = 7'b0010011; funct3 = 3'b000; funct7_5 = 1'b0; zero = 1'b0;
    mem_bus.mem_ready = 1'b1;
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      #1;
      check("rst.req", mem_bus.mem_req, 0);
      check("rst.en", {ir_write, pc_write, reg_write, mem_bus.mem_write, instr_done}, 0);
      check("rst.ill", illegal, 0);
      next_cycle();
    end
    rst = 1'b0;

    // addi x10,x0,5 cycle by cycle
    #1;
    check("addi.c1.req", mem_bus.mem_req, 1);
    check("addi.c1.srcb", alu_src_b, 2'b10);
    check("addi.c1.irw", {ir_write, pc_write}, 2'b11);
    check("addi.c1.done", instr_done, 0);
    next_cycle(); #1;
    check("addi.c2.srcab", {alu_src_a, alu_src_b}, 4'b0101);
    check("addi.c2.en", {ir_write, pc_write, reg_write, mem_bus.mem_req}, 0);
    next_cycle(); #1;
    check("addi.c3.alu", alu_control, 3'b000);
    check("addi.c3.srcab", {alu_src_a, alu_src_b}, 4'b1001);
    check("addi.c3.rw", reg_write, 0);
    next_cycle(); #1;
    check("addi.c4.rw", reg_write, 1);
    check("addi.c4.rsrc", result_src, 2'b00);
    check("addi.c4.done", instr_done, 1);
    next_cycle(); #1;
    check("addi.c5.fetch", mem_bus.mem_req, 1);
    check("addi.c5.done", instr_done, 0);

    //        tag        op          f3      f7    z     rdy        cyc pcw rw rs     req mw imm2   imm3   alu3
    run_instr("lw_wait", 7'b0000011, 3'b010, 1'b0, 1'b0, 16'hFF9C, 9, 1, 1, 2'b01, 6, 0, 2'b00, 2'b00, 3'b000);
    run_instr("lw",      7'b0000011, 3'b010, 1'b0, 1'b0, 16'hFFFF, 5, 1, 1, 2'b01, 2, 0, 2'b00, 2'b00, 3'b000);
    run_instr("sw_wait", 7'b0100011, 3'b010, 1'b0, 1'b0, 16'hFFF7, 5, 1, 0, 2'b00, 3, 2, 2'b00, 2'b01, 3'b000);
    run_instr("bne_nz",  7'b1100011, 3'b001, 1'b0, 1'b0, 16'hFFFF, 3, 2, 0, 2'b00, 1, 0, 2'b10, 2'b00, 3'b001);
    run_instr("bne_z",   7'b1100011, 3'b001, 1'b0, 1'b1, 16'hFFFF, 3, 1, 0, 2'b00, 1, 0, 2'b10, 2'b00, 3'b001);
    run_instr("beq_z",   7'b1100011, 3'b000, 1'b0, 1'b1, 16'hFFFF, 3, 2, 0, 2'b00, 1, 0, 2'b10, 2'b00, 3'b001);
    run_instr("beq_nz",  7'b1100011, 3'b000, 1'b0, 1'b0, 16'hFFFF, 3, 1, 0, 2'b00, 1, 0, 2'b10, 2'b00, 3'b001);
    run_instr("jal",     7'b1101111, 3'b000, 1'b0, 1'b0, 16'hFFFF, 4, 2, 1, 2'b00, 1, 0, 2'b11, 2'b00, 3'b000);
    run_instr("sub",     7'b0110011, 3'b000, 1'b1, 1'b0, 16'hFFFF, 4, 1, 1, 2'b00, 1, 0, 2'b00, 2'b00, 3'b001);
    run_instr("or",      7'b0110011, 3'b110, 1'b0, 1'b0, 16'hFFFF, 4, 1, 1, 2'b00, 1, 0, 2'b00, 2'b00, 3'b011);
    run_instr("slti",    7'b0010011, 3'b010, 1'b0, 1'b0, 16'hFFFF, 4, 1, 1, 2'b00, 1, 0, 2'b00, 2'b00, 3'b101);
    run_instr("addi_f7", 7'b0010011, 3'b000, 1'b1, 1'b0, 16'hFFFF, 4, 1, 1, 2'b00, 1, 0, 2'b00, 2'b00, 3'b000);
    run_instr("andi",    7'b0010011, 3'b111, 1'b0, 1'b0, 16'hFFFF, 4, 1, 1, 2'b00, 1, 0, 2'b00, 2'b00, 3'b010);

    // reset while lw waits in MEMREAD
    op = 7'b0000011; funct3 = 3'b010; mem_bus.mem_ready = 1'b1;
    next_cycle(); next_cycle(); next_cycle();
    mem_bus.mem_ready = 1'b0;
    #1;
    check("mrst.req_before", mem_bus.mem_req, 1);
    check("mrst.adr", mem_bus.adr_src, 1);
    rst = 1'b1;
    #1;
    check("mrst.req_in_rst", mem_bus.mem_req, 0);
    check("mrst.en_in_rst", {reg_write, pc_write, ir_write, instr_done}, 0);
    next_cycle();
    rst = 1'b0;
    run_instr("post_rst", 7'b0010011, 3'b000, 1'b0, 1'b0, 16'hFFFF, 4, 1, 1, 2'b00, 1, 0, 2'b00, 2'b00, 3'b000);

    trap_run("trap_op", 7'b1111111, 3'b000, 3);
    trap_run("trap_sll", 7'b0110011, 3'b001, 4);
    trap_run("trap_blt", 7'b1100011, 3'b100, 4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle control sequencer for the RV32I core. It replaces the single-cycle decode path with a state machine, so that the register file, ALU, sign extender, PC register and one shared instruction/data memory are used across several cycles per instruction. It decodes `op`/`funct3`/`funct7_5` and consumes the ALU `zero` flag. It drives every enable, mux select and ALU control, and handshakes with a variable-latency memory through `mem_req`/`mem_ready`.

## Interface
- `clk`  in  1  core clock; all state changes on rising edge
- `rst`  in  1  synchronous, active-high reset
- `op`  in  7  instr[6:0], taken from the instruction register
- `funct3`  in  3  instr[14:12]
- `funct7_5`  in  1  instr[30]
- `zero`  in  1  ALU result == 0
- `mem_ready`  in  1  memory completes the current access this cycle
- `mem_req`  out  1  memory access request
- `MemWrite`  out  1  the request is a store
- `AdrSrc`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `IRWrite`  out  1  load the instruction and OldPC registers
- `PCWrite`  out  1  load the PC from the result bus
- `RegWrite`  out  1  register-file write enable
- `ALUSrcA`  out  2  00 = PC, 01 = OldPC, 10 = rs1 data
- `ALUSrcB`  out  2  00 = rs2 data, 01 = ImmOp, 10 = constant 4
- `ResultSrc`  out  2  00 = ALUOut, 01 = memory data, 10 = ALU result
- `ImmSrc`  out  2  00 = I, 01 = S, 10 = B, 11 = J
- `ALUControl`  out  3  000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt
- `instr_done`  out  1  one-cycle pulse in the final cycle of each instruction
- `illegal`  out  1  sticky flag: an unsupported encoding was decoded

## Operation
- State machine states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP.
- FETCH
  - Outputs: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10.
  - Holds while mem_ready=0.
  - When mem_ready=1: IRWrite=1 and PCWrite=1 (PC←PC+4), then go to DECODE.
- DECODE
  - Outputs: ALUSrcA=01, ALUSrcB=01, add, giving ALUOut = OldPC + imm.
  - ImmSrc: 10 if op=1100011, 11 if op=1101111, else 00.
  - Next state by op:
    - 0000011 (lw) or 0100011 (sw) → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BRANCH
    - 1101111 → JAL
    - any other op → TRAP
- MEMADR
  - Outputs: ALUSrcA=10, ALUSrcB=01, add; ImmSrc=00 for lw, 01 for sw.
  - Goes to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD
  - Outputs: mem_req=1, AdrSrc=1.
  - Holds while mem_ready=0; on mem_ready=1 goes to MEMWB.
- MEMWB
  - Outputs: ResultSrc=01, RegWrite=1, instr_done=1.
  - Goes to FETCH.
- MEMWRITE
  - Outputs: mem_req=1, MemWrite=1, AdrSrc=1.
  - On mem_ready=1: instr_done=1, then go to FETCH.
- EXECR / EXECI
  - Outputs: ALUSrcA=10; ALUSrcB=00 (EXECR) or 01 (EXECI).
  - ALUControl is decoded from funct3:
    - 000 → add; in EXECR, sub when funct7_5=1
    - 010 → slt
    - 110 → or
    - 111 → and
  - Any other funct3 → TRAP.
  - Goes to ALUWB.
- ALUWB
  - Outputs: ResultSrc=00, RegWrite=1, instr_done=1.
  - Goes to FETCH.
- BRANCH
  - Outputs: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, instr_done=1.
  - PCWrite = (funct3=000 & zero) | (funct3=001 & ~zero).
  - Any other funct3 → TRAP, with no PCWrite and no instr_done.
  - Otherwise goes to FETCH.
- JAL
  - Outputs: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1.
  - This writes PC ← branch target, computes ALUOut ← OldPC+4, then goes to ALUWB.
- TRAP
  - illegal=1; every enable, mem_req and instr_done is 0.
  - Stays in TRAP until rst.
- Default values: any output not listed for a state is 0.

## Timing
- Reset
  - rst high at a rising edge puts the machine in FETCH and clears `illegal`.
  - While rst is high, all write enables (IRWrite, PCWrite, RegWrite, MemWrite) are forced to 0, as are mem_req and instr_done.
  - Reset mid-instruction abandons the instruction with no partial writes after that edge.
- Outputs are a Moore decode of the state register, except:
  - the FETCH IRWrite/PCWrite and the MEMWRITE instr_done, which are gated by mem_ready;
  - the BRANCH PCWrite, which depends on funct3 and zero.
- Handshake:
  - mem_req stays high, with address and MemWrite stable, until the cycle in which mem_ready=1.
  - Exactly one transfer occurs per ready cycle.
  - mem_ready outside FETCH, MEMREAD and MEMWRITE is ignored.
- Instruction latency with zero-wait memory (mem_ready tied high):
  - R-type / I-ALU: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - branch: 3 cycles
  - jal: 4 cycles
- Each wait cycle on memory adds exactly one cycle.
- instr_done occurs exactly once per retired instruction and never in TRAP.

## Test plan
- Reset: hold rst 3 cycles with mem_ready=1 → mem_req=0 and all enables 0; the cycle after release, state is FETCH with mem_req=1.
- addi x10,x0,5 (0x00500513), mem_ready tied 1 → IRWrite in cycle 1, EXECI with ALUControl=000 and ALUSrcB=01, RegWrite in cycle 4, instr_done pulse; 4 cycles total.
- lw with mem_ready low for 2 cycles in both FETCH and MEMREAD → 9 cycles total; mem_req held steady throughout; RegWrite with ResultSrc=01 only in MEMWB.
- bne x10,x0,-4 → PCWrite in BRANCH when zero=0; no PCWrite when zero=1; 3 cycles either way.
- jal → PCWrite in FETCH and again in JAL, then RegWrite in ALUWB; 4 cycles.
- op=1111111 → TRAP after DECODE; illegal=1 and stays so; no enables for 20 cycles; rst returns the machine to FETCH with illegal=0.
